// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared constants and types for the common data bus (CDB) arbiter.
//   - Default widths for ROB aliases and result data.
//   - TRUE/FALSE single-bit constants.
//   - RENAMED_ZERO: the rename tag meaning "no producer"; it is also the idle
//     value the CDB alias register takes after reset or rollback.
//   - cdb_src_e: identifies which producer a broadcast came from.
//   - rr_pick: two-way round-robin selection used by the arbiter.
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

   localparam int ROB_ID_W_DEFAULT = 4;
   localparam int DATA_W_DEFAULT   = 32;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int RENAMED_ZERO = 0;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } cdb_src_e;

   // Returns {found, source}. When both sources have work, the one that did
   // not win last time is chosen; otherwise whichever is non-empty.
   function automatic logic [1:0] rr_pick(input logic     alu_ne,
                                          input logic     lsb_ne,
                                          input cdb_src_e last);
      logic [1:0] pick;
      pick = {FALSE, SRC_ALU};
      if (alu_ne && lsb_ne) begin
         pick = {TRUE, (last == SRC_ALU) ? SRC_LSB : SRC_ALU};
      end else if (alu_ne) begin
         pick = {TRUE, SRC_ALU};
      end else if (lsb_ne) begin
         pick = {TRUE, SRC_LSB};
      end
      return pick;
   endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// cdb_fifo
//   Small per-producer result FIFO in front of the CDB arbiter.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     push          write din at the tail (ignored when full)
//     pop           drop the head entry (ignored when empty)
//     flush         empty the FIFO; wins over same-cycle push/pop
//     din           entry to write
//     dout          head entry, combinational read
//     empty, full   occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module cdb_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] head_reg;
   logic [PTR_W-1:0] tail_reg;
   logic [CNT_W-1:0] count_reg;

   logic do_push;
   logic do_pop;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CNT_W'(DEPTH));

   // A full FIFO refuses input even if it is popping in the same cycle.
   assign do_push = push & ~full & ~flush & ~rst;
   assign do_pop  = pop & ~empty & ~flush & ~rst;

   assign dout = mem_reg[head_reg];

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[tail_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (do_push) begin
            tail_reg <= tail_reg + PTR_W'(1);
         end
         if (do_pop) begin
            head_reg <= head_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Shares the common data bus between the ALU and the load/store buffer.
//   Each producer feeds its own cdb_fifo; one result per cycle is granted
//   round-robin and driven onto registered CDB outputs.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     rdy                            global enable, low freezes everything
//     rollback_signal                misprediction flush (same effect as rst)
//     alu_valid/alias/result/ready   ALU producer handshake
//     lsb_valid/alias/result/ready   LSB producer handshake
//     cdb_valid/alias/result/src     registered broadcast (src 0=ALU, 1=LSB)
// ---------------------------------------------------------------------------
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int ROB_ID_W   = ROB_ID_W_DEFAULT,
   parameter int DATA_W     = DATA_W_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                rollback_signal,
   input  logic                alu_valid,
   input  logic [ROB_ID_W-1:0] alu_alias,
   input  logic [DATA_W-1:0]   alu_result,
   output logic                alu_ready,
   input  logic                lsb_valid,
   input  logic [ROB_ID_W-1:0] lsb_alias,
   input  logic [DATA_W-1:0]   lsb_result,
   output logic                lsb_ready,
   output logic                cdb_valid,
   output logic [ROB_ID_W-1:0] cdb_alias,
   output logic [DATA_W-1:0]   cdb_result,
   output logic                cdb_src
);

   localparam int ENTRY_W = ROB_ID_W + DATA_W;
   localparam int NUM_SRC = 2;

   // Index 0 is the ALU, index 1 the LSB, matching cdb_src_e.
   logic [NUM_SRC-1:0] src_valid;
   logic [NUM_SRC-1:0] src_ready;
   logic [NUM_SRC-1:0] src_push;
   logic [NUM_SRC-1:0] src_pop;
   logic [NUM_SRC-1:0] src_empty;
   logic [NUM_SRC-1:0] src_full;
   logic [ENTRY_W-1:0] src_din  [NUM_SRC];
   logic [ENTRY_W-1:0] src_dout [NUM_SRC];

   logic [1:0]         pick;
   logic               grant_any;
   cdb_src_e           grant_src;
   logic               grant_en;
   logic [ENTRY_W-1:0] grant_entry;

   cdb_src_e           last_grant_reg;
   logic               cdb_valid_reg;
   logic [ROB_ID_W-1:0] cdb_alias_reg;
   logic [DATA_W-1:0]  cdb_result_reg;
   cdb_src_e           cdb_src_reg;

   assign src_valid  = {lsb_valid, alu_valid};
   assign src_din[0] = {alu_alias, alu_result};
   assign src_din[1] = {lsb_alias, lsb_result};

   assign alu_ready = src_ready[0];
   assign lsb_ready = src_ready[1];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         // Rollback and pause both block acceptance so a producer keeps
         // its data instead of losing it into a flushed or frozen FIFO.
         assign src_ready[gi] = rdy & ~rollback_signal & ~src_full[gi];
         assign src_push[gi]  = src_valid[gi] & src_ready[gi];
         assign src_pop[gi]   = grant_en & (grant_src == cdb_src_e'(gi));

         cdb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (src_push[gi]),
            .pop   (src_pop[gi]),
            .flush (rollback_signal),
            .din   (src_din[gi]),
            .dout  (src_dout[gi]),
            .empty (src_empty[gi]),
            .full  (src_full[gi])
         );
      end
   endgenerate

   // Eligibility comes from the FIFO state before this edge's push, which
   // gives every result at least one cycle of residency (no bypass).
   assign pick        = rr_pick(~src_empty[0], ~src_empty[1], last_grant_reg);
   assign grant_any   = pick[1];
   assign grant_src   = cdb_src_e'(pick[0]);
   assign grant_en    = rdy & ~rollback_signal & ~rst & grant_any;
   assign grant_entry = src_dout[pick[0]];

   always_ff @(posedge clk) begin
      if (rst || rollback_signal) begin
         last_grant_reg <= SRC_LSB;   // ALU wins the first tie
         cdb_valid_reg  <= FALSE;
         cdb_alias_reg  <= ROB_ID_W'(RENAMED_ZERO);
         cdb_result_reg <= '0;
         cdb_src_reg    <= SRC_ALU;
      end else if (rdy) begin
         if (grant_any) begin
            cdb_valid_reg  <= TRUE;
            cdb_alias_reg  <= grant_entry[ENTRY_W-1:DATA_W];
            cdb_result_reg <= grant_entry[DATA_W-1:0];
            cdb_src_reg    <= grant_src;
            last_grant_reg <= grant_src;
         end else begin
            // Payload holds; only the valid flag drops.
            cdb_valid_reg <= FALSE;
         end
      end
   end

   assign cdb_valid  = cdb_valid_reg;
   assign cdb_alias  = cdb_alias_reg;
   assign cdb_result = cdb_result_reg;
   assign cdb_src    = cdb_src_reg;

endmodule
